// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake and
// holds the word in an instruction register until the control unit acks it.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ready
// VALID | instr/pc hold an unconsumed instruction, waiting for instr_ack
// HALT  | misaligned redirect taken, parked until reset
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      Opcode,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            instr_ack,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            misaligned,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t state;
    logic   req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            misaligned  <= 1'b0;
            instret     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        state       <= VALID;
                        req_q       <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (instr_ack) begin
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
                        pc          <= PCSrc ? PCTarget : pc_plus4;
                        // A misaligned target is still loaded so it can be inspected
                        if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                            state      <= HALT;
                            req_q      <= 1'b0;
                            misaligned <= 1'b1;
                        end else begin
                            state <= FETCH;
                            req_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= HALT;
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Request drops immediately while reset is held, not one edge later
    assign imem_req  = req_q & ~reset;
    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign Opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at RESET_PC = 0, a second
// at RESET_PC = 0xFFFF_FFFC for the PC wrap case.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset, imem_ready, instr_ack, PCSrc;
    logic [31:0] imem_rdata, PCTarget;
    logic        imem_req, instr_valid, misaligned, funct7;
    logic [31:0] imem_addr, instr, pc, pc_plus4, instret;
    logic [6:0]  Opcode;
    logic [2:0]  funct3;

    logic        reset2, imem_ready2, instr_ack2, PCSrc2;
    logic [31:0] imem_rdata2, PCTarget2;
    logic        imem_req2, instr_valid2, misaligned2, funct7_2;
    logic [31:0] imem_addr2, instr2, pc2, pc_plus4_2, instret2;
    logic [6:0]  Opcode2;
    logic [2:0]  funct3_2;

    int n_vec  = 0;
    int n_miss = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .Opcode(Opcode), .funct3(funct3), .funct7(funct7), .pc(pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .misaligned(misaligned),
        .instret(instret)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready2), .imem_rdata(imem_rdata2), .instr(instr2),
        .Opcode(Opcode2), .funct3(funct3_2), .funct7(funct7_2), .pc(pc2),
        .pc_plus4(pc_plus4_2), .instr_valid(instr_valid2), .instr_ack(instr_ack2),
        .PCSrc(PCSrc2), .PCTarget(PCTarget2), .misaligned(misaligned2),
        .instret(instret2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
        PCSrc = 1'b0; PCTarget = '0;
        reset2 = 1'b1; imem_ready2 = 1'b0; imem_rdata2 = '0; instr_ack2 = 1'b0;
        PCSrc2 = 1'b0; PCTarget2 = '0;

        // Reset state
        tick(); tick();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_instr", instr, 32'h13);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instret", instret, 32'h0);
        check_eq("rst_misaligned", 32'(misaligned), 32'h0);
        check_eq("rst_req_low", 32'(imem_req), 32'h0);

        // Sequential fetch, zero wait
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
        #1;
        check_eq("f0_req", 32'(imem_req), 32'h1);
        check_eq("f0_addr", imem_addr, 32'h0);
        tick();
        check_eq("v0_valid", 32'(instr_valid), 32'h1);
        check_eq("v0_instr", instr, 32'h33);
        check_eq("v0_opcode", 32'(Opcode), 32'h33);
        check_eq("v0_req", 32'(imem_req), 32'h0);
        check_eq("v0_pc_plus4", pc_plus4, 32'h4);
        imem_ready = 1'b0; instr_ack = 1'b1;
        tick();
        check_eq("f1_addr", imem_addr, 32'h4);
        check_eq("f1_instret", instret, 32'h1);
        check_eq("f1_valid", 32'(instr_valid), 32'h0);

        // Wait states at pc=4; ack/PCSrc during FETCH must be ignored
        imem_rdata = 32'h4000_5033; instr_ack = 1'b1; PCSrc = 1'b1; PCTarget = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("wait_req", 32'(imem_req), 32'h1);
            check_eq("wait_addr", imem_addr, 32'h4);
            check_eq("wait_valid", 32'(instr_valid), 32'h0);
        end
        check_eq("wait_instret", instret, 32'h1);
        imem_ready = 1'b1; instr_ack = 1'b0; PCSrc = 1'b0;
        tick();
        check_eq("v1_valid", 32'(instr_valid), 32'h1);
        check_eq("v1_instr", instr, 32'h4000_5033);
        check_eq("v1_funct3", 32'(funct3), 32'h5);
        check_eq("v1_funct7", 32'(funct7), 32'h1);

        // imem_ready in VALID ignored; PCSrc without ack ignored
        imem_rdata = 32'hFFFF_FFFF; PCSrc = 1'b1; PCTarget = 32'h200;
        tick();
        check_eq("hold_instr", instr, 32'h4000_5033);
        check_eq("hold_pc", pc, 32'h4);
        check_eq("hold_valid", 32'(instr_valid), 32'h1);
        imem_ready = 1'b0; PCSrc = 1'b0; instr_ack = 1'b1;
        tick();
        check_eq("f2_addr", imem_addr, 32'h8);
        check_eq("f2_instret", instret, 32'h2);

        // Redirect at pc=8
        instr_ack = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ready = 1'b0; instr_ack = 1'b1; PCSrc = 1'b1; PCTarget = 32'h100;
        tick();
        check_eq("redir_addr", imem_addr, 32'h100);
        check_eq("redir_instret", instret, 32'h3);
        check_eq("redir_req", 32'(imem_req), 32'h1);

        // Misaligned redirect -> HALT
        instr_ack = 1'b0; PCSrc = 1'b0; imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; instr_ack = 1'b1; PCSrc = 1'b1; PCTarget = 32'h102;
        tick();
        check_eq("mis_flag", 32'(misaligned), 32'h1);
        check_eq("mis_pc", pc, 32'h102);
        check_eq("mis_req", 32'(imem_req), 32'h0);
        check_eq("mis_valid", 32'(instr_valid), 32'h0);
        imem_ready = 1'b1; PCSrc = 1'b0;
        tick(); tick();
        check_eq("halt_req", 32'(imem_req), 32'h0);
        check_eq("halt_valid", 32'(instr_valid), 32'h0);
        check_eq("halt_instret", instret, 32'h4);
        check_eq("halt_flag", 32'(misaligned), 32'h1);
        reset = 1'b1; imem_ready = 1'b0; instr_ack = 1'b0;
        tick();
        check_eq("halt_rst_flag", 32'(misaligned), 32'h0);
        check_eq("halt_rst_pc", pc, 32'h0);

        // Reach pc=0x40, then reset during a FETCH wait with imem_ready pulsing
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ready = 1'b0; instr_ack = 1'b1; PCSrc = 1'b1; PCTarget = 32'h40;
        tick();
        instr_ack = 1'b0; PCSrc = 1'b0;
        tick();
        check_eq("f40_addr", imem_addr, 32'h40);
        check_eq("f40_instret", instret, 32'h1);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hABCD_1234; instr_ack = 1'b1;
        tick();
        check_eq("mid_rst_instr", instr, 32'h13);
        check_eq("mid_rst_pc", pc, 32'h0);
        check_eq("mid_rst_instret", instret, 32'h0);
        check_eq("mid_rst_valid", 32'(instr_valid), 32'h0);
        reset = 1'b0; imem_ready = 1'b0; instr_ack = 1'b0;
        tick();
        check_eq("post_rst_instr", instr, 32'h13);
        check_eq("post_rst_req", 32'(imem_req), 32'h1);

        // PC wrap on the second instance
        tick();
        reset2 = 1'b0; imem_ready2 = 1'b1; imem_rdata2 = 32'h0000_0013;
        #1;
        check_eq("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc_plus4", pc_plus4_2, 32'h0);
        imem_ready2 = 1'b0; instr_ack2 = 1'b1;
        tick();
        check_eq("wrap_pc", pc2, 32'h0);
        check_eq("wrap_next_plus4", pc_plus4_2, 32'h4);
        check_eq("wrap_misaligned", 32'(misaligned2), 32'h0);
        check_eq("wrap_instret", instret2, 32'h1);
        instr_ack2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control unit. Owns the program counter and fetches instructions from instruction memory over a request/ready handshake.
- Holds each fetched word in an instruction register and presents Opcode/funct3/funct7 fields to the control unit.
- Advances to PC+4, or redirects to a branch/jump target when the control unit asserts PCSrc.
- Counts retired instructions and flags misaligned redirect targets.

Parameters:
- XLEN, 32: width of PC, addresses, instruction word.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address, always equals pc.
- imem_ready  in  1  memory response valid; imem_rdata is sampled on the same edge.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction register contents.
- Opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].
- pc  out  XLEN  address of instr.
- pc_plus4  out  XLEN  pc + 4, wraps modulo 2^XLEN.
- instr_valid  out  1  instr/pc hold a fetched, unconsumed instruction.
- instr_ack  in  1  downstream consumes the current instruction this cycle.
- PCSrc  in  1  take PCTarget instead of pc_plus4; qualified by instr_ack.
- PCTarget  in  XLEN  branch/jump target address.
- misaligned  out  1  sticky: a redirect target with [1:0] != 0 was taken.
- instret  out  32  retired-instruction counter.

Behaviour:
- Reset is synchronous and active-high. On a reset edge:
  - pc = RESET_PC, instr = 32'h0000_0013 (NOP), instr_valid = 0, misaligned = 0, instret = 0, state = FETCH.
  - imem_req is forced 0 while reset is high.
  - Any in-flight response is discarded.
- States:
  - FETCH: imem_req = 1, imem_addr = pc. On imem_ready: instr <= imem_rdata, then go to VALID. Otherwise stay in FETCH with imem_addr held stable.
  - VALID: instr_valid = 1, imem_req = 0. On instr_ack:
    - instret <= instret + 1 (wraps at 2^32).
    - pc <= PCSrc ? PCTarget : pc_plus4.
    - Go to FETCH.
    - If PCSrc = 1 and PCTarget[1:0] != 0, go to HALT instead and set misaligned = 1; pc still loads PCTarget.
  - HALT: imem_req = 0, instr_valid = 0. Stay until reset.
- Latency:
  - imem_ready in the first FETCH cycle gives instr_valid on the next cycle. Minimum is 2 cycles per instruction (FETCH, VALID).
  - Each memory wait cycle adds one cycle.
- PCSrc and PCTarget are ignored unless state = VALID and instr_ack = 1.
- instr_ack outside VALID is ignored: no counter or PC change.
- imem_ready outside FETCH is ignored; instr is not overwritten.
- instr, pc and the decoded fields stay constant for the whole VALID period.
- pc_plus4 and decoded fields are combinational from the registers.
- Reset asserted in any state, including mid-FETCH wait or HALT, has full priority over all other inputs that cycle.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

Test Plan:
1. Reset, then sequential fetch: reset high 2 cycles, memory returns 32'h0000_0033 with zero wait, ack every VALID cycle -> imem_addr sequence 0x0, 0x4, 0x8; instret = 3 after third ack; Opcode = 7'b0110011.
2. Wait states: imem_ready delayed 3 cycles at pc = 0x4 -> imem_req and imem_addr = 0x4 held for 4 cycles; instr_valid rises the cycle after imem_ready.
3. Redirect: at pc = 0x8 drive instr_ack = 1, PCSrc = 1, PCTarget = 0x100 -> next imem_addr = 0x100. Also drive PCSrc = 1 with instr_ack = 0 -> pc unchanged, instr_valid stays 1.
4. Misaligned: instr_ack = 1, PCSrc = 1, PCTarget = 0x102 -> misaligned = 1, imem_req = 0, instr_valid = 0 until reset; reset clears misaligned and pc = RESET_PC.
5. Reset mid-operation: reset during a FETCH wait at pc = 0x40, with imem_ready pulsing in the same cycle -> instr = 0x13, pc = RESET_PC, instret = 0, instr_valid = 0.
6. Wrap: RESET_PC = 32'hFFFF_FFFC, ack with PCSrc = 0 -> pc = 0x0, pc_plus4 = 0x4, misaligned = 0.
